// File: rtl/mul_share_pkg.sv
// Shared types and helpers for the round-robin shared multiplier (mul_share_arbiter).
// Struct fields are sized for the largest supported build (32 requesters, 32-bit operands).
package mul_share_pkg;

  localparam int MAX_REQ   = 32;
  localparam int MAX_ID_W  = 5;
  localparam int MAX_RES_W = 64;

  typedef struct packed {
    logic                 valid;
    logic [MAX_ID_W-1:0]  id;
    logic [MAX_RES_W-1:0] result;
  } rsp_t;

  function automatic int result_width(input int in_w);
    return 2 * in_w;
  endfunction

  // Index after g in the rotating order, wrapping at n.
  function automatic int rr_next(input int g, input int n);
    return (g + 1 >= n) ? 0 : g + 1;
  endfunction

  // First set bit of req at or after ptr, wrapping modulo n; -1 when nothing is requested.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] req, input int ptr, input int n);
    int pick;
    int idx;
    pick = -1;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = ptr + i;
      if (idx >= n) begin
        idx = idx - n;
      end
      if ((i < n) && (pick < 0) && req[idx]) begin
        pick = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mul_share_rr_arb.sv
// Round-robin grant with a rotating pointer; combinational grant, pointer moves past the winner.
// While stalled no grant is issued and the pointer holds.
module mul_share_rr_arb
  import mul_share_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_REQ-1:0]  i_req,
  input  logic                i_stall,
  output logic [ID_WIDTH-1:0] o_gnt_idx,
  output logic                o_gnt_vld
);

  logic [ID_WIDTH-1:0] rr_ptr_q;
  logic [ID_WIDTH-1:0] rr_ptr_d;
  logic [MAX_REQ-1:0]  req_ext;
  int                  pick;

  always_comb begin
    req_ext              = '0;
    req_ext[NUM_REQ-1:0] = i_req;
    pick                 = rr_pick(req_ext, int'(rr_ptr_q), NUM_REQ);
    o_gnt_vld            = (pick >= 0) && !i_stall;
    o_gnt_idx            = (pick >= 0) ? ID_WIDTH'(pick) : '0;
    // A grant is always a handshake: the winner is by construction a valid requester.
    rr_ptr_d             = o_gnt_vld ? ID_WIDTH'(rr_next(pick, NUM_REQ)) : rr_ptr_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// One registered multiplier shared round-robin by NUM_REQ requesters; accept-to-result latency 2.
// Output backpressure freezes both stages and withholds grants; MUL_SHARE_SIGNED_EN selects signed products.
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int IN_DATA_WIDTH = 8,
  parameter int ID_WIDTH      = $clog2(NUM_REQ)
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic [NUM_REQ-1:0]                     i_req_valid,
  output logic [NUM_REQ-1:0]                     o_req_ready,
  input  logic [NUM_REQ*IN_DATA_WIDTH-1:0]       i_req_a,
  input  logic [NUM_REQ*IN_DATA_WIDTH-1:0]       i_req_b,
  output logic                                   o_rsp_valid,
  input  logic                                   i_rsp_ready,
  output logic [ID_WIDTH-1:0]                    o_rsp_id,
  output logic [result_width(IN_DATA_WIDTH)-1:0] o_rsp_result
);

  localparam int RES_W = result_width(IN_DATA_WIDTH);

  logic                     stall;
  logic [ID_WIDTH-1:0]      gnt_idx;
  logic                     gnt_vld;
  logic [IN_DATA_WIDTH-1:0] gnt_a;
  logic [IN_DATA_WIDTH-1:0] gnt_b;
  logic [RES_W-1:0]         product;

  logic                     v1_q, v1_d;
  logic [IN_DATA_WIDTH-1:0] a1_q, a1_d;
  logic [IN_DATA_WIDTH-1:0] b1_q, b1_d;
  logic [ID_WIDTH-1:0]      id1_q, id1_d;
  rsp_t                     rsp_q, rsp_d;
  logic                     unused_rsp_hi;

  assign stall = rsp_q.valid & ~i_rsp_ready;

  mul_share_rr_arb #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_req     (i_req_valid),
    .i_stall   (stall),
    .o_gnt_idx (gnt_idx),
    .o_gnt_vld (gnt_vld)
  );

  always_comb begin
    o_req_ready = '0;
    if (gnt_vld) begin
      o_req_ready[gnt_idx] = 1'b1;
    end
    gnt_a = i_req_a[int'(gnt_idx)*IN_DATA_WIDTH +: IN_DATA_WIDTH];
    gnt_b = i_req_b[int'(gnt_idx)*IN_DATA_WIDTH +: IN_DATA_WIDTH];
  end

`ifdef MUL_SHARE_SIGNED_EN
  logic signed [RES_W-1:0] a1_sx;
  logic signed [RES_W-1:0] b1_sx;

  // Sign-extend to full width first so the truncated product is the exact two's-complement result.
  always_comb begin
    a1_sx   = {{IN_DATA_WIDTH{a1_q[IN_DATA_WIDTH-1]}}, a1_q};
    b1_sx   = {{IN_DATA_WIDTH{b1_q[IN_DATA_WIDTH-1]}}, b1_q};
    product = a1_sx * b1_sx;
  end
`else
  always_comb begin
    product = RES_W'(a1_q) * RES_W'(b1_q);
  end
`endif

  // Operand and product data only load behind a valid, so bubbles cost no toggling.
  always_comb begin
    v1_d  = v1_q;
    a1_d  = a1_q;
    b1_d  = b1_q;
    id1_d = id1_q;
    rsp_d = rsp_q;
    if (!stall) begin
      v1_d        = gnt_vld;
      rsp_d.valid = v1_q;
      if (gnt_vld) begin
        a1_d  = gnt_a;
        b1_d  = gnt_b;
        id1_d = gnt_idx;
      end
      if (v1_q) begin
        rsp_d.id     = MAX_ID_W'(id1_q);
        rsp_d.result = MAX_RES_W'(product);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q  <= 1'b0;
      a1_q  <= '0;
      b1_q  <= '0;
      id1_q <= '0;
      rsp_q <= '0;
    end else begin
      v1_q  <= v1_d;
      a1_q  <= a1_d;
      b1_q  <= b1_d;
      id1_q <= id1_d;
      rsp_q <= rsp_d;
    end
  end

  assign o_rsp_valid   = rsp_q.valid;
  assign o_rsp_id      = rsp_q.id[ID_WIDTH-1:0];
  assign o_rsp_result  = rsp_q.result[RES_W-1:0];
  assign unused_rsp_hi = ^{rsp_q.id >> ID_WIDTH, rsp_q.result >> RES_W};

endmodule
